// File: rtl/hc161_counter.sv
// hc161_counter: synchronous presettable binary counter, 74HC161 equivalent.
// Optional build macro: HC161_MODULO_EN (when defined, count wraps at
// MODULUS-1 instead of all-ones, and TC flags MODULUS-1).
// Pin names follow the 74HC161 data sheet so the part drops into the
// cpu74hc161 datapath unchanged. MRN is active-high despite its name.
module hc161_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             CP,
  input  logic             MRN,
  input  logic             CEP,
  input  logic             CET,
  input  logic             PEN,
  input  logic [WIDTH-1:0] Dn,
  output logic [WIDTH-1:0] Qn,
  output logic             TC
);

  // Reject out-of-range configurations at elaboration time.
  if ((WIDTH < 1) || (WIDTH > 16)) begin : g_width_bad
    $error("hc161_counter: WIDTH must be in 1..16");
  end
  if ((MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_modulus_bad
    $error("hc161_counter: MODULUS must be in 2..2**WIDTH");
  end

  // Terminal value: the state at which TC can assert and, in modulo
  // mode, the state from which an increment returns to zero.
`ifdef HC161_MODULO_EN
  localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);
`else
  localparam logic [WIDTH-1:0] TERM = {WIDTH{1'b1}};
`endif

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic             w_at_term;
  logic             w_count_en;

  assign w_at_term  = (r_q == TERM);
  // Both enables must be high to count; PEN=0 (load) overrides counting.
  assign w_count_en = PEN & CEP & CET;

  // Next-state selection in priority order: load, count, hold.
  always_comb begin
    w_q_next = r_q;
    if (!PEN) begin
      w_q_next = Dn;
    end else if (w_count_en) begin
`ifdef HC161_MODULO_EN
      // A loaded value above TERM is not forced back into range; it
      // simply counts up and wraps naturally at 2**WIDTH.
      if (w_at_term) begin
        w_q_next = '0;
      end else begin
        w_q_next = r_q + 1'b1;
      end
`else
      w_q_next = r_q + 1'b1;
`endif
    end
  end

  // State register; reset is asynchronous and dominates any clock edge.
  always_ff @(posedge CP or posedge MRN) begin
    if (MRN) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign Qn = r_q;
  // TC is combinational so a cascaded stage sees it in the same cycle.
  // During reset r_q is zero and TERM is never zero, so TC stays low.
  assign TC = CET & w_at_term;

endmodule

// File: tb/tb_hc161_counter.sv
// tb_hc161_counter: directed self-checking bench for hc161_counter.
// Covers reset, load priority, count/hold, wrap and TC gating, and a
// two-stage cascade. Build with +define+HC161_MODULO_EN to run the
// modulo-10 sequence instead of the binary wrap section.
module tb_hc161_counter;

`ifdef HC161_MODULO_EN
  localparam int TB_MOD = 10;
`else
  localparam int TB_MOD = 16;
`endif

  // Clock/reset and stimulus signals
  logic       clk;
  logic       mrn;
  logic       cep;
  logic       cet;
  logic       pen;
  logic [3:0] dn;
  logic [3:0] qn;
  logic       tc;

  // Cascade signals
  logic       c_cep;
  logic       c_cet;
  logic       c_pen;
  logic [7:0] c_d;
  logic [3:0] q0;
  logic [3:0] q1;
  logic       tc0;
  logic       tc1;

  int n_cmp;
  int n_err;

  hc161_counter #(.WIDTH(4), .MODULUS(TB_MOD)) u_dut (
    .CP(clk), .MRN(mrn), .CEP(cep), .CET(cet), .PEN(pen),
    .Dn(dn), .Qn(qn), .TC(tc)
  );

  hc161_counter #(.WIDTH(4), .MODULUS(16)) u_c0 (
    .CP(clk), .MRN(mrn), .CEP(c_cep), .CET(c_cet), .PEN(c_pen),
    .Dn(c_d[3:0]), .Qn(q0), .TC(tc0)
  );

  hc161_counter #(.WIDTH(4), .MODULUS(16)) u_c1 (
    .CP(clk), .MRN(mrn), .CEP(c_cep), .CET(tc0), .PEN(c_pen),
    .Dn(c_d[7:4]), .Qn(q1), .TC(tc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    mrn = 1'b1; cep = 1'b0; cet = 1'b0; pen = 1'b1; dn = 4'h0;
    c_cep = 1'b0; c_cet = 1'b1; c_pen = 1'b1; c_d = 8'h00;

    // Reset state
    #1;
    check("rst_q_async", {4'h0, qn}, 8'h00);
    tick(); tick();
    check("rst_q", {4'h0, qn}, 8'h00);
    check("rst_tc", {7'h0, tc}, 8'h00);

    // Async reset mid-cycle from Qn=9
    mrn = 1'b0;
    pen = 1'b0; dn = 4'h9;
    tick();
    check("load9", {4'h0, qn}, 8'h09);
    pen = 1'b1; cet = 1'b1;
    #2;
    mrn = 1'b1;
    #1;
    check("async_rst_q", {4'h0, qn}, 8'h00);
    check("async_rst_tc", {7'h0, tc}, 8'h00);
    // Reset dominates edges even with load and count requested
    pen = 1'b0; dn = 4'h5; cep = 1'b1;
    tick(); tick();
    check("rst_hold_q", {4'h0, qn}, 8'h00);
    check("rst_hold_tc", {7'h0, tc}, 8'h00);
    mrn = 1'b0;

    // Load priority over counting
    pen = 1'b0; cep = 1'b1; cet = 1'b1; dn = 4'hA;
    tick();
    check("load_prio", {4'h0, qn}, 8'h0A);
    pen = 1'b0; cep = 1'b0; dn = 4'h3;
    tick();
    check("load3", {4'h0, qn}, 8'h03);

    // Count 3 -> 7
    pen = 1'b1; cep = 1'b1; cet = 1'b1;
    tick(); check("cnt4", {4'h0, qn}, 8'h04);
    tick(); check("cnt5", {4'h0, qn}, 8'h05);
    tick(); check("cnt6", {4'h0, qn}, 8'h06);
    tick(); check("cnt7", {4'h0, qn}, 8'h07);
    // Hold with CEP=0
    cep = 1'b0;
    tick(); tick(); tick();
    check("hold_cep", {4'h0, qn}, 8'h07);
    // Hold with CET=0
    cep = 1'b1; cet = 1'b0;
    tick(); tick(); tick();
    check("hold_cet", {4'h0, qn}, 8'h07);
    check("hold_tc", {7'h0, tc}, 8'h00);

`ifdef HC161_MODULO_EN
    // Modulo-10 sequence from 0
    pen = 1'b0; dn = 4'h0; cet = 1'b1;
    tick();
    check("mod_load0", {4'h0, qn}, 8'h00);
    check("mod_tc0", {7'h0, tc}, 8'h00);
    pen = 1'b1; cep = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("mod_cnt", {4'h0, qn}, 8'(i));
      check("mod_tc", {7'h0, tc}, (i == 9) ? 8'h01 : 8'h00);
    end
    cet = 1'b0;
    #1;
    check("mod_tc_cet0", {7'h0, tc}, 8'h00);
    cet = 1'b1;
    tick();
    check("mod_wrap", {4'h0, qn}, 8'h00);
    check("mod_wrap_tc", {7'h0, tc}, 8'h00);
    // Out-of-range load counts up and wraps at 16
    pen = 1'b0; dn = 4'hC;
    tick();
    check("mod_load12", {4'h0, qn}, 8'h0C);
    pen = 1'b1;
    tick(); check("mod_13", {4'h0, qn}, 8'h0D);
    tick(); check("mod_14", {4'h0, qn}, 8'h0E);
    tick(); check("mod_15", {4'h0, qn}, 8'h0F);
    check("mod_15_tc", {7'h0, tc}, 8'h00);
    tick(); check("mod_0", {4'h0, qn}, 8'h00);
`else
    // Binary wrap and TC
    pen = 1'b0; dn = 4'hE; cet = 1'b1;
    tick();
    check("wrap_loadE", {4'h0, qn}, 8'h0E);
    check("wrap_tcE", {7'h0, tc}, 8'h00);
    pen = 1'b1; cep = 1'b1;
    tick();
    check("wrap_F", {4'h0, qn}, 8'h0F);
    check("wrap_tcF", {7'h0, tc}, 8'h01);
    cet = 1'b0;
    #1;
    check("tc_cet_drop", {7'h0, tc}, 8'h00);
    cet = 1'b1; cep = 1'b0; pen = 1'b0; dn = 4'h2;
    #1;
    check("tc_no_cep_pen", {7'h0, tc}, 8'h01);
    pen = 1'b1; cep = 1'b1;
    tick();
    check("wrap_0", {4'h0, qn}, 8'h00);
    check("wrap_tc0", {7'h0, tc}, 8'h00);
`endif

    // Two-stage cascade
    c_pen = 1'b0; c_d = 8'h0E; c_cep = 1'b1; c_cet = 1'b1;
    tick();
    check("casc_load", {q1, q0}, 8'h0E);
    c_pen = 1'b1;
    tick();
    check("casc_0F", {q1, q0}, 8'h0F);
    check("casc_tc0", {7'h0, tc0}, 8'h01);
    tick();
    check("casc_10", {q1, q0}, 8'h10);
    check("casc_tc1", {7'h0, tc1}, 8'h00);
    c_pen = 1'b0; c_d = 8'hFE;
    tick();
    c_pen = 1'b1;
    tick();
    check("casc_FF", {q1, q0}, 8'hFF);
    check("casc_tc_hi", {7'h0, tc1}, 8'h01);
    tick();
    check("casc_wrap", {q1, q0}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hc161_counter.md
Name: hc161_counter

Overview:
- Synchronous presettable binary counter, functionally equivalent to a 74HC161.
- Provides a 4-bit default count, synchronous parallel load, two count enables and a ripple-carry terminal-count output.
- Used as a program-counter / sequencing element in the cpu74hc161 datapath.
- Cascadable: TC of one stage drives CET of the next.

Parameters:
- WIDTH, 4, counter width in bits; legal range 1..16.
- MODULUS, 16, count modulus; used only when HC161_MODULO_EN is defined; legal range 2..2^WIDTH.

Ports:
- CP  input  1  clock; all state changes on its rising edge except reset.
- MRN  input  1  master reset, asynchronous, active-high. The name is kept for pin compatibility; 1 = reset.
- CEP  input  1  count enable parallel, active-high.
- CET  input  1  count enable trickle, active-high; also gates TC.
- PEN  input  1  parallel load enable, active-low (0 = load).
- Dn  input  WIDTH  parallel load data.
- Qn  output  WIDTH  counter state, registered.
- TC  output  1  terminal count, combinational.

Behaviour:
- Reset:
  - MRN=1 forces Qn=0 immediately, independent of CP.
  - Qn stays 0 while MRN=1, and TC=0 during reset.
  - On MRN deassertion, the first rising CP edge with MRN=0 is evaluated normally.
  - Reset dominates a simultaneous clock edge.
- Rising CP edge with MRN=0, in strict priority order:
  1. PEN=0: Qn <= Dn. CEP and CET are ignored.
  2. PEN=1, CEP=1 and CET=1: Qn <= Qn+1, modulo 2^WIDTH (all-ones wraps to 0).
  3. Otherwise: Qn holds.
- Latency:
  - Load and increment take effect one edge later; Qn is valid after the edge.
  - No pipeline stages.
- TC:
  - TC = CET AND (Qn == all ones), purely combinational.
  - Does not depend on CEP or PEN.
  - Goes high in the same cycle Qn reaches all-ones and drops as soon as CET falls.
- Qn is a direct register output with no combinational path from inputs.
- X/Z on inputs is not handled specially; inputs are sampled at the edge as given.
- Cascading: CET(n+1)=TC(n) with a shared CP and CEP gives a WIDTH*k-bit synchronous counter.

Optional Feature:
- HC161_MODULO_EN defined:
  - Counting follows the sequence 0..MODULUS-1.
  - When Qn==MODULUS-1, an increment yields 0.
  - TC = CET AND (Qn==MODULUS-1).
  - A load of a value >= MODULUS is accepted as-is. Increments from it proceed normally, wrapping at 2^WIDTH to 0.
  - Load and reset priority are unchanged.
- HC161_MODULO_EN undefined:
  - Pure binary behaviour as above.
  - MODULUS is ignored.

Test Plan:
- Async reset: Qn=9, MRN pulse 1 mid-cycle (no CP edge) -> Qn=0 and TC=0 immediately; Qn stays 0 through edges while MRN=1.
- Load priority: MRN=0, PEN=0, CEP=1, CET=1, Dn=4'hA, one edge -> Qn=4'hA (no increment); PEN=0, CEP=0, Dn=3 -> Qn=3.
- Count and hold: PEN=1, CEP=CET=1 from Qn=3, 4 edges -> Qn=7; then CEP=0 for 3 edges -> Qn=7; then CEP=1, CET=0 for 3 edges -> Qn=7.
- Wrap and TC: load 4'hE, count -> Qn=F with TC=1 in that cycle; next edge Qn=0 and TC=0; at Qn=F, dropping CET -> TC=0 combinationally.
- Cascade: two instances with TC0->CET1, load 8'h0E, count 2 edges -> {Q1,Q0}=8'h10.
- HC161_MODULO_EN with MODULUS=10: count from 0 -> 0..9 then 0; TC=1 only at Qn=9 with CET=1; load 12 then 4 edges -> 13,14,15,0.
